step_gen: RTL and testbench

STEP_GEN -- requirements
Module: step_gen

---
 rtl/step_gen.sv | 182 ++++++++++++++++++
 tb/tb_step_gen.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_gen.sv
// Step/direction pulse generator: a DDA accumulator requests one step per 2^FRAC_BITS of travel.
// Define STEP_GEN_ENDSTOP_EN to add the endstop input and the sticky endstop_hit flag.

module step_gen #(
  parameter int FRAC_BITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_tick,
  input  logic               enable,
  input  logic signed [63:0] speed,
  input  logic [7:0]         pulse_len,
  input  logic [7:0]         dir_setup,
  input  logic               clear_flags,
`ifdef STEP_GEN_ENDSTOP_EN
  input  logic               endstop,
  output logic               endstop_hit,
`endif
  output logic               step,
  output logic               dir,
  output logic               busy,
  output logic signed [31:0] position,
  output logic               missed
);

  typedef enum logic [1:0] {S_IDLE, S_DIR_SETUP, S_PULSE, S_LOW} state_e;

  localparam logic signed [63:0] SPEED_MAX = (64'sd1 <<< FRAC_BITS) - 64'sd1;

  state_e             state_q, state_d;
  logic signed [63:0] acc_q, acc_d, speed_c;
  logic               req_q, req_d, req_dir_q, req_dir_d;
  logic               pend_valid_q, pend_valid_d, pend_dir_q, pend_dir_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               step_q, step_d, dir_q, dir_d, missed_q, missed_d;
  logic signed [31:0] pos_q, pos_d;
  logic               endstop_in, req_blocked, req_v, pend_v, new_dir;
  logic [7:0]         pulse_init, setup_init;

`ifdef STEP_GEN_ENDSTOP_EN
  logic hit_q, hit_d;

  assign endstop_in = endstop;
  always_comb hit_d = (hit_q & ~clear_flags) | req_blocked;
  always_ff @(posedge clk) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= hit_d;
  end
  assign endstop_hit = hit_q;
`else
  assign endstop_in = 1'b0;
`endif

  // Zero lengths behave as one cycle so a misprogrammed driver still gets a valid pulse.
  assign pulse_init = (pulse_len == 8'd0) ? 8'd0 : pulse_len - 8'd1;
  assign setup_init = (dir_setup == 8'd0) ? 8'd0 : dir_setup - 8'd1;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    speed_c = speed;
    if (speed > SPEED_MAX)       speed_c = SPEED_MAX;
    else if (speed < -SPEED_MAX) speed_c = -SPEED_MAX;
    acc_d     = acc_q;
    req_d     = 1'b0;
    req_dir_d = speed_c[63];
    if (step_tick && enable) begin
      acc_d = acc_q + speed_c;
      req_d = (acc_d[FRAC_BITS] != acc_q[FRAC_BITS]) && (speed_c != '0);
    end
  end

  // Negative-direction work is discarded while the endstop is active.
  assign req_blocked = endstop_in && req_q && req_dir_q;
  assign req_v       = req_q && !req_blocked;
  assign pend_v      = pend_valid_q && !(endstop_in && pend_dir_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    dir_d        = dir_q;
    pos_d        = pos_q;
    pend_valid_d = pend_v;
    pend_dir_d   = pend_dir_q;
    missed_d     = missed_q & ~clear_flags;
    new_dir      = dir_q;

    if (state_q != S_IDLE && req_v) begin
      if (pend_v) begin
        missed_d = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_dir_d   = req_dir_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pend_v || req_v) begin
          new_dir = pend_v ? pend_dir_q : req_dir_q;
          if (pend_v) begin
            // Pending slot is consumed now, so a simultaneous request takes its place.
            pend_valid_d = req_v;
            pend_dir_d   = req_dir_q;
          end
          if (new_dir != dir_q) begin
            dir_d   = new_dir;
            state_d = S_DIR_SETUP;
            cnt_d   = setup_init;
          end else begin
            state_d = S_PULSE;
            step_d  = 1'b1;
            cnt_d   = pulse_init;
            pos_d   = dir_q ? pos_q - 32'sd1 : pos_q + 32'sd1;
          end
        end
      end
      S_DIR_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_PULSE;
          step_d  = 1'b1;
          cnt_d   = pulse_init;
          pos_d   = dir_q ? pos_q - 32'sd1 : pos_q + 32'sd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_LOW;
          step_d  = 1'b0;
          cnt_d   = pulse_init;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_LOW: begin
        if (cnt_q == 8'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (req_v && state_q != S_IDLE && pend_v) missed_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      req_q        <= 1'b0;
      req_dir_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= 1'b0;
      cnt_q        <= '0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      pos_q        <= '0;
      missed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      req_q        <= req_d;
      req_dir_q    <= req_dir_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      pos_q        <= pos_d;
      missed_q     <= missed_d;
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign position = pos_q;
  assign missed   = missed_q;
  assign busy     = (state_q != S_IDLE) || pend_valid_q;

endmodule

// File: tb/tb_step_gen.sv
// Self-checking bench for step_gen: an accumulator model pushes expected steps into a scoreboard,
// a negedge monitor pops and compares them as step pulses appear.

module tb_step_gen;

  logic               clk = 1'b0;
  logic               rst, step_tick, enable, clear_flags;
  logic signed [63:0] speed;
  logic [7:0]         pulse_len, dir_setup;
  logic               step, dir, busy, missed;
  logic signed [31:0] position;
`ifdef STEP_GEN_ENDSTOP_EN
  logic               endstop, endstop_hit;
`endif

  always #5 clk = ~clk;

  step_gen dut (
    .clk        (clk),
    .rst        (rst),
    .step_tick  (step_tick),
    .enable     (enable),
    .speed      (speed),
    .pulse_len  (pulse_len),
    .dir_setup  (dir_setup),
    .clear_flags(clear_flags),
`ifdef STEP_GEN_ENDSTOP_EN
    .endstop    (endstop),
    .endstop_hit(endstop_hit),
`endif
    .step       (step),
    .dir        (dir),
    .busy       (busy),
    .position   (position),
    .missed     (missed)
  );

  typedef struct {
    logic   dir;
    int     pos;
    longint rise;   // expected cycle of the rising edge, -1 when not timed
  } exp_t;

  localparam longint SPEED_LIM = 64'sd4294967295;

  exp_t   sb_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  longint model_acc;
  int     model_pos;
  logic   model_dir;
  int     budget;
  logic   endstop_tb;
  int     eff_pulse, eff_setup;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic longint sat(input longint s);
    if (s > SPEED_LIM)  return SPEED_LIM;
    if (s < -SPEED_LIM) return -SPEED_LIM;
    return s;
  endfunction

  // Accumulator model; budget caps how many requests a burst can get accepted.
  task automatic model_tick(input longint spd, input bit timed);
    longint sc, old_acc;
    logic   rdir;
    exp_t   e;
    sc        = sat(spd);
    old_acc   = model_acc;
    model_acc = old_acc + sc;
    if (sc == 0 || old_acc[32] == model_acc[32]) return;
    rdir = (sc < 0);
    if (endstop_tb && rdir) return;
    if (budget == 0) return;
    budget--;
    e.rise    = timed ? cyc + 2 + ((rdir != model_dir) ? eff_setup : 0) : -1;
    model_dir = rdir;
    model_pos = rdir ? model_pos - 1 : model_pos + 1;
    e.dir     = rdir;
    e.pos     = model_pos;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input longint spd, input bit en, input bit timed);
    speed     = spd;
    enable    = en;
    step_tick = 1'b1;
    if (en) model_tick(spd, timed);
    @(posedge clk);
    #1;
    step_tick = 1'b0;
  endtask

  task automatic ticks_spaced(input longint spd, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick(spd, 1'b1, 1'b1);
      idle(gap - 1);
    end
  endtask

  task automatic set_timing(input logic [7:0] pl, input logic [7:0] ds);
    pulse_len = pl;
    dir_setup = ds;
    eff_pulse = (pl == 8'd0) ? 1 : int'(pl);
    eff_setup = (ds == 8'd0) ? 1 : int'(ds);
  endtask

  task automatic reset_model;
    sb_q.delete();
    model_acc = 0;
    model_pos = 0;
    model_dir = 1'b0;
    budget    = 1000;
  endtask

  task automatic do_reset;
    rst         = 1'b1;
    step_tick   = 1'b0;
    clear_flags = 1'b0;
    idle(1);
    rst = 1'b0;
    reset_model();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 500) begin
      idle(1);
      n++;
    end
    check(tag, sb_q.size(), 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Step monitor
  logic prev_step = 1'b0;
  logic rst_seen  = 1'b1;
  logic have_fall = 1'b0;
  int   high_cnt  = 0;
  int   low_cnt   = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst || rst_seen) begin
      prev_step = step;
      high_cnt  = 0;
      low_cnt   = 0;
      have_fall = 1'b0;
    end else begin
      if (step && !prev_step) begin
        if (sb_q.size() == 0) begin
          check("unexpected_step", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("step_dir", dir, mon_e.dir);
          check("step_pos", position, mon_e.pos);
          if (mon_e.rise >= 0) check("step_time", cyc, mon_e.rise);
          if (have_fall) check("low_time_min", low_cnt >= eff_pulse, 1);
        end
        high_cnt = 1;
      end else if (step) begin
        high_cnt++;
      end else if (prev_step) begin
        check("high_time", high_cnt, eff_pulse);
        have_fall = 1'b1;
        low_cnt   = 1;
      end else begin
        low_cnt++;
      end
      prev_step = step;
    end
    rst_seen = rst;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    step_tick   = 1'b0;
    enable      = 1'b0;
    speed       = '0;
    clear_flags = 1'b0;
    endstop_tb  = 1'b0;
`ifdef STEP_GEN_ENDSTOP_EN
    endstop = 1'b0;
`endif
    set_timing(8'd2, 8'd3);
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_step", step, 0);
    check("rst_dir", dir, 0);
    check("rst_busy", busy, 0);
    check("rst_pos", position, 0);
    check("rst_missed", missed, 0);
`ifdef STEP_GEN_ENDSTOP_EN
    check("rst_endstop_hit", endstop_hit, 0);
`endif
    @(posedge clk);
    #1;

    // Half-step speed: every second tick crosses a step boundary.
    ticks_spaced(64'sd2147483648, 8, 20);
    drain("fwd_drain");
    check("fwd_pos", position, 4);
    check("fwd_dir", dir, 0);
    check("fwd_missed", missed, 0);

    // Over-range negative speed saturates; first step waits out dir setup.
    ticks_spaced(-64'sd4294967296, 4, 20);
    drain("rev_drain");
    check("rev_pos", position, 0);
    check("rev_dir", dir, 1);

    // Ticks with enable low during a pulse leave the accumulator untouched.
    tick(-64'sd4294967296, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(-64'sd4294967296, 1'b0, 1'b0);
    idle(20);
    tick(-64'sd4294967296, 1'b1, 1'b1);
    drain("hold_drain");
    check("hold_pos", position, -2);

    // Burst of ticks every cycle: one step served, one pending, rest dropped.
    do_reset();
    set_timing(8'd10, 8'd3);
    budget = 2;
    for (int i = 0; i < 5; i++) tick(SPEED_LIM, 1'b1, i < 2);
    check("burst_busy", busy, 1);
    drain("burst_drain");
    check("burst_missed", missed, 1);
    check("burst_pos", position, 2);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    check("clear_missed", missed, 0);

    // Drop coinciding with clear_flags: the set wins.
    budget = 2;
    for (int i = 0; i < 3; i++) tick(SPEED_LIM, 1'b1, i == 0);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    check("set_wins_missed", missed, 1);
    drain("set_wins_drain");
    check("set_wins_pos", position, 4);
    budget      = 1000;
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    check("clear_missed2", missed, 0);

    // Zero lengths behave as one cycle.
    do_reset();
    set_timing(8'd0, 8'd0);
    ticks_spaced(SPEED_LIM, 4, 6);
    ticks_spaced(-(64'sd1 <<< 40), 3, 6);
    drain("zero_len_drain");
    check("zero_len_pos", position, 0);
    check("zero_len_dir", dir, 1);

    // Reset during a pulse.
    do_reset();
    set_timing(8'd10, 8'd3);
    tick(SPEED_LIM, 1'b1, 1'b1);
    idle(3);
    tick(SPEED_LIM, 1'b1, 1'b1);
    idle(3);
    check("mid_pulse_step", step, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    reset_model();
    check("mid_rst_step", step, 0);
    check("mid_rst_pos", position, 0);
    check("mid_rst_busy", busy, 0);
    ticks_spaced(SPEED_LIM, 2, 4);
    drain("post_rst_drain");
    check("post_rst_pos", position, 1);

`ifdef STEP_GEN_ENDSTOP_EN
    do_reset();
    set_timing(8'd2, 8'd3);
    endstop    = 1'b1;
    endstop_tb = 1'b1;
    ticks_spaced(-SPEED_LIM, 3, 10);
    drain("es_neg_drain");
    check("es_neg_pos", position, 0);
    check("es_hit", endstop_hit, 1);
    check("es_neg_dir", dir, 0);
    ticks_spaced(SPEED_LIM, 3, 10);
    drain("es_pos_drain");
    check("es_pos_pos", position, 3);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    check("es_hit_clear", endstop_hit, 0);
    endstop    = 1'b0;
    endstop_tb = 1'b0;
`endif

    check("final_queue", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
